checkbits_latency_monitor: RTL and testbench
============================================

Name: checkbits_latency_monitor

Overview:
- Synthesizable, parametrised on-chip version of the checkbits latency measurement done today by the caravel FIR testbench.
- Watches the firmware status word on mprj_io[31:16]. Times each start-marker to end-marker iteration in wb_clk_i cycles.
- Stores per-iteration latencies plus total, min and max, so firmware or the logic analyzer (LA) can read results without a simulator.
- Sits in user_project_wrapper beside the FIR block.

Parameters:
- DATA_W, 16, width of the checkbits word.
- MARK_W, 8, number of low bits compared against the start/end markers.
- START_MARK, 8'hA5, start-of-iteration marker.
- END_MARK, 8'h5A, end-of-iteration marker.
- DONE_CODE, 16'hAB51, full-word code that ends the run early.
- MAX_ITER, 4, number of latency slots (must be 2 or more).
- CNT_W, 32, counter width.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- checkbits  in  DATA_W  monitored status word.
- enable  in  1  arms the monitor when high.
- clear  in  1  synchronous clear of all results; returns the FSM to IDLE.
- rd_idx  in  $clog2(MAX_ITER)  slot select for reading.
- rd_lat  out  CNT_W  latency stored in slot rd_idx (combinational read).
- busy  out  1  high while in the COUNT state.
- lat_valid  out  1  one-cycle pulse when an iteration latency is captured.
- last_lat  out  CNT_W  most recently captured latency.
- total_lat  out  CNT_W  saturating sum of captured latencies.
- min_lat  out  CNT_W  smallest captured latency.
- max_lat  out  CNT_W  largest captured latency.
- iter_cnt  out  $clog2(MAX_ITER)+1  number of iterations captured.
- overflow  out  1  sticky; set when any counter or the sum saturates.
- done  out  1  sticky; set when MAX_ITER iterations are captured or DONE_CODE is seen.

Behaviour:
- Reset (async wb_rst_i=1): state IDLE. All outputs 0 except min_lat = all-ones. All slots 0.
- Marker matches use registered inputs:
  - start = (checkbits[MARK_W-1:0] == START_MARK)
  - end = (checkbits[MARK_W-1:0] == END_MARK)
  - code = (checkbits == DONE_CODE)
- FSM states: IDLE, ARMED, COUNT, DONE.
- IDLE: moves to ARMED next cycle when enable=1.
- ARMED:
  - code => DONE (done=1). code has priority over start.
  - start => COUNT, with cnt=0.
  - Otherwise stays in ARMED.
- COUNT:
  - Each cycle, cnt increments, saturating at all-ones; saturation sets overflow.
  - On end: latency = cnt+1 (saturating). Equivalently, latency = cycle index of end sample minus cycle index of start sample.
  - In the capture cycle: write slot[iter_cnt] = latency, last_lat = latency, total_lat += latency (saturating; saturation sets overflow), update min_lat/max_lat, increment iter_cnt, pulse lat_valid the following cycle.
  - After capture: if iter_cnt reaches MAX_ITER => DONE, else => ARMED.
  - start seen again while in COUNT is ignored (no restart).
  - code seen while in COUNT is ignored.
- DONE: holds all results. Ignores checkbits and enable. Left only via clear or reset.
- enable=0 in ARMED or COUNT: return to IDLE. Any in-progress count is discarded. Stored results are kept.
- clear=1: overrides every other event in the same cycle. State -> IDLE. Results, flags and slots return to their reset values.
- A marker held for many cycles counts as a single event: start is accepted only in ARMED, end only in COUNT.
- A start on the cycle immediately after a capture is accepted, because ARMED is entered that cycle.
- rd_idx >= iter_cnt returns the slot's current value (0 after reset/clear).
- Mid-operation reset: immediate asynchronous return to the reset state.

Test Plan:
- Basic timing: enable=1; checkbits=16'h00A5 at cycle 10; 16'h765A at cycle 110 -> lat_valid pulse; last_lat=100; iter_cnt=1; busy low after capture.
- Three iterations of latencies 100, 250, 80, then 16'hAB51 -> slots 0..2 = 100/250/80; total_lat=430; min_lat=80; max_lat=250; done=1; further A5/5A traffic ignored.
- MAX_ITER=4 with four iterations of 10, 20, 30, 40 -> done=1 after the fourth capture; iter_cnt=4; a fifth A5 does not set busy.
- CNT_W=8 with a 300-cycle iteration -> last_lat=8'hFF, overflow=1 and stays set; a later 5-cycle iteration still records 5.
- enable dropped 50 cycles into COUNT -> IDLE; no capture, iter_cnt unchanged. Re-enable plus a 20-cycle iteration -> slot0=20.
- clear asserted in the same cycle as end -> no capture; all outputs at reset values. Also: async wb_rst_i pulse mid-COUNT -> immediate reset values.

Source files
------------

// File: rtl/checkbits_latency_monitor.sv
// Times start-marker to end-marker iterations on the firmware checkbits word and
// keeps per-iteration latencies plus total/min/max for firmware or LA readback.
module checkbits_latency_monitor #(
  parameter int                 DATA_W     = 16,
  parameter int                 MARK_W     = 8,
  parameter logic [MARK_W-1:0]  START_MARK = 8'hA5,
  parameter logic [MARK_W-1:0]  END_MARK   = 8'h5A,
  parameter logic [DATA_W-1:0]  DONE_CODE  = 16'hAB51,
  parameter int                 MAX_ITER   = 4,
  parameter int                 CNT_W      = 32
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [DATA_W-1:0]           checkbits,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [$clog2(MAX_ITER)-1:0] rd_idx,
  output logic [CNT_W-1:0]            rd_lat,
  output logic                        busy,
  output logic                        lat_valid,
  output logic [CNT_W-1:0]            last_lat,
  output logic [CNT_W-1:0]            total_lat,
  output logic [CNT_W-1:0]            min_lat,
  output logic [CNT_W-1:0]            max_lat,
  output logic [$clog2(MAX_ITER):0]   iter_cnt,
  output logic                        overflow,
  output logic                        done
);

  localparam int                 IDX_W     = $clog2(MAX_ITER);
  localparam int                 ITER_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [ITER_W-1:0]  ITER_LAST = ITER_W'(MAX_ITER - 1);
  localparam logic [ITER_W-1:0]  ITER_ONE  = ITER_W'(1);

  typedef enum logic [1:0] {IDLE, ARMED, COUNT, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] cb_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  slots [MAX_ITER];

  logic              start_hit;
  logic              end_hit;
  logic              code_hit;
  logic [CNT_W-1:0]  lat_now;
  logic [CNT_W:0]    sum_ext;
  logic [CNT_W-1:0]  sum_sat;

  assign start_hit = (cb_q[MARK_W-1:0] == START_MARK);
  assign end_hit   = (cb_q[MARK_W-1:0] == END_MARK);
  assign code_hit  = (cb_q == DONE_CODE);

  // Latency of the iteration ending this cycle, and the running sum, both clamped at all-ones.
  assign lat_now = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
  assign sum_ext = {1'b0, total_lat} + {1'b0, lat_now};
  assign sum_sat = sum_ext[CNT_W] ? CNT_MAX : sum_ext[CNT_W-1:0];

  assign rd_lat = slots[rd_idx];
  assign busy   = (state == COUNT);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      cb_q      <= '0;
      cnt       <= '0;
      lat_valid <= 1'b0;
      last_lat  <= '0;
      total_lat <= '0;
      min_lat   <= CNT_MAX;
      max_lat   <= '0;
      iter_cnt  <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < MAX_ITER; i++) slots[i] <= '0;
    end else begin
      cb_q      <= checkbits;
      lat_valid <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        cnt       <= '0;
        last_lat  <= '0;
        total_lat <= '0;
        min_lat   <= CNT_MAX;
        max_lat   <= '0;
        iter_cnt  <= '0;
        overflow  <= 1'b0;
        done      <= 1'b0;
        for (int i = 0; i < MAX_ITER; i++) slots[i] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (enable) state <= ARMED;
          end
          ARMED: begin
            if (!enable) begin
              state <= IDLE;
            end else if (code_hit) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (start_hit) begin
              state <= COUNT;
              cnt   <= '0;
            end
          end
          // Repeated start or done-code samples are deliberately ignored while counting.
          COUNT: begin
            if (!enable) begin
              state <= IDLE;
            end else if (end_hit) begin
              slots[iter_cnt[IDX_W-1:0]] <= lat_now;
              last_lat  <= lat_now;
              total_lat <= sum_sat;
              if (cnt == CNT_MAX || sum_ext[CNT_W]) overflow <= 1'b1;
              if (lat_now < min_lat) min_lat <= lat_now;
              if (lat_now > max_lat) max_lat <= lat_now;
              iter_cnt  <= iter_cnt + ITER_ONE;
              lat_valid <= 1'b1;
              if (iter_cnt == ITER_LAST) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= ARMED;
              end
            end else if (cnt == CNT_MAX) begin
              overflow <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_checkbits_latency_monitor.sv
// Drives a 32-bit and an 8-bit counter monitor with the same checkbits traffic and
// compares both against a latency-list model built from whole-iteration lengths.
module tb_checkbits_latency_monitor;

  localparam int MAX_ITER = 4;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [15:0] checkbits;
  logic        enable;
  logic        clear;
  logic [1:0]  rd_idx;

  logic [31:0] rd_lat32, last32, total32, min32, max32;
  logic        busy32, lv32, ov32, done32;
  logic [2:0]  iter32;
  logic [7:0]  rd_lat8, last8, total8, min8, max8;
  logic        busy8, lv8, ov8, done8;
  logic [2:0]  iter8;

  int checks = 0;
  int errors = 0;

  longint m_lat [MAX_ITER];
  int     m_n;
  longint m_total, m_min, m_max, m_last;
  bit     m_done;

  checkbits_latency_monitor u_dut32 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .checkbits(checkbits), .enable(enable),
    .clear(clear), .rd_idx(rd_idx), .rd_lat(rd_lat32), .busy(busy32), .lat_valid(lv32),
    .last_lat(last32), .total_lat(total32), .min_lat(min32), .max_lat(max32),
    .iter_cnt(iter32), .overflow(ov32), .done(done32)
  );

  checkbits_latency_monitor #(.CNT_W(8)) u_dut8 (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .checkbits(checkbits), .enable(enable),
    .clear(clear), .rd_idx(rd_idx), .rd_lat(rd_lat8), .busy(busy8), .lat_valid(lv8),
    .last_lat(last8), .total_lat(total8), .min_lat(min8), .max_lat(max8),
    .iter_cnt(iter8), .overflow(ov8), .done(done8)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [15:0] noise();
    logic [15:0] w;
    do w = 16'($urandom); while (w[7:0] == 8'hA5 || w[7:0] == 8'h5A || w == 16'hAB51);
    return w;
  endfunction

  // Mid-iteration filler that sometimes repeats the start marker or the done code.
  function automatic logic [15:0] busy_noise();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return {8'($urandom), 8'hA5};
    if (r == 1) return 16'hAB51;
    return noise();
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MAX_ITER; i++) m_lat[i] = 0;
    m_n = 0; m_total = 0; m_min = 0; m_max = 0; m_last = 0; m_done = 0;
  endtask

  task automatic model_capture(input longint len);
    m_lat[m_n] = len;
    m_last     = len;
    m_total    = m_total + len;
    m_min      = (m_n == 0 || len < m_min) ? len : m_min;
    m_max      = (len > m_max) ? len : m_max;
    m_n++;
    if (m_n == MAX_ITER) m_done = 1;
  endtask

  task automatic applyStimulus(input logic [15:0] word);
    checkbits = word;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic fill(input int n);
    repeat (n) begin
      applyStimulus(busy_noise());
      tick(1);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkDut(input string tag, input int w, input logic b, input logic lv,
                          input logic [31:0] last, input logic [31:0] total,
                          input logic [31:0] mn, input logic [31:0] mx,
                          input logic [2:0] it, input logic ov, input logic dn);
    longint full;
    full = sat(64'h7FFF_FFFF_FFFF, w);
    checkOutput($sformatf("%s w%0d busy", tag, w), 64'(b), 0);
    checkOutput($sformatf("%s w%0d lat_valid", tag, w), 64'(lv), 0);
    checkOutput($sformatf("%s w%0d last_lat", tag, w), 64'(last), sat(m_last, w));
    checkOutput($sformatf("%s w%0d total_lat", tag, w), 64'(total), sat(m_total, w));
    checkOutput($sformatf("%s w%0d min_lat", tag, w), 64'(mn), (m_n == 0) ? full : sat(m_min, w));
    checkOutput($sformatf("%s w%0d max_lat", tag, w), 64'(mx), sat(m_max, w));
    checkOutput($sformatf("%s w%0d iter_cnt", tag, w), 64'(it), 64'(m_n));
    checkOutput($sformatf("%s w%0d overflow", tag, w), 64'(ov), 64'(m_total > full));
    checkOutput($sformatf("%s w%0d done", tag, w), 64'(dn), 64'(m_done));
  endtask

  task automatic checkAll(input string tag);
    checkDut(tag, 32, busy32, lv32, last32, total32, min32, max32, iter32, ov32, done32);
    checkDut(tag, 8, busy8, lv8, 32'(last8), 32'(total8), 32'(min8), 32'(max8), iter8, ov8, done8);
    for (int i = 0; i < MAX_ITER; i++) begin
      rd_idx = 2'(i);
      #1;
      checkOutput($sformatf("%s slot%0d w32", tag, i), 64'(rd_lat32), (i < m_n) ? sat(m_lat[i], 32) : 0);
      checkOutput($sformatf("%s slot%0d w8", tag, i), 64'(rd_lat8), (i < m_n) ? sat(m_lat[i], 8) : 0);
    end
  endtask

  task automatic check_capture(input string tag, input longint len);
    model_capture(len);
    checkOutput({tag, " lat_valid w32"}, 64'(lv32), 1);
    checkOutput({tag, " lat_valid w8"}, 64'(lv8), 1);
    checkOutput({tag, " last_lat w32"}, 64'(last32), sat(len, 32));
    checkOutput({tag, " last_lat w8"}, 64'(last8), sat(len, 8));
  endtask

  // One start-to-end iteration of len cycles, starting from the armed state.
  task automatic run_iter(input int len, input string tag);
    applyStimulus({8'($urandom), 8'hA5});
    tick(1);
    fill(len - 1);
    if (len >= 2) checkOutput({tag, " busy mid"}, 64'(busy32 & busy8), 1);
    applyStimulus({8'($urandom), 8'h5A});
    tick(2);
    check_capture(tag, len);
    applyStimulus(noise());
    tick(1);
    checkAll(tag);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    model_reset();
    checkAll(tag);
    applyStimulus(noise());
    tick(2);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    enable   = 1'b0;
    clear    = 1'b0;
    rd_idx   = '0;
    checkbits = '0;
    model_reset();
    tick(3);
    checkAll("reset");
    wb_rst_i = 1'b0;
    tick(2);
    checkAll("idle");

    $display("[TB] basic timing and three-iteration run");
    enable = 1'b1;
    repeat (8) begin applyStimulus(noise()); tick(1); end
    run_iter(100, "basic100");
    run_iter(250, "iter250");
    run_iter(80, "iter80");
    applyStimulus(16'hAB51);
    tick(2);
    m_done = 1;
    applyStimulus(noise());
    tick(1);
    checkAll("done_code");
    applyStimulus(16'h00A5);
    for (int i = 0; i < 12; i++) begin
      if (i == 6) applyStimulus(16'h765A);
      tick(1);
      checkOutput($sformatf("after_done lv cyc%0d", i), 64'(lv32 | lv8), 0);
      checkOutput($sformatf("after_done busy cyc%0d", i), 64'(busy32 | busy8), 0);
    end
    checkAll("after_done");

    $display("[TB] four iterations with back-to-back start");
    do_clear("clear1");
    applyStimulus(16'h00A5);
    tick(1);
    fill(9);
    applyStimulus(16'h765A);
    tick(1);
    applyStimulus(16'h12A5);
    tick(1);
    check_capture("chain10", 10);
    fill(19);
    applyStimulus(16'h345A);
    tick(2);
    check_capture("chain20", 20);
    applyStimulus(noise());
    tick(1);
    checkAll("chain20");
    run_iter(30, "iter30");
    run_iter(40, "iter40");
    applyStimulus(16'h00A5);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput($sformatf("fifth_start busy cyc%0d", i), 64'(busy32 | busy8), 0);
    end
    checkAll("full");

    $display("[TB] saturation");
    do_clear("clear2");
    run_iter(300, "long300");
    run_iter(5, "short5");

    $display("[TB] enable drop and re-enable");
    do_clear("clear3");
    applyStimulus(16'h00A5);
    tick(1);
    fill(50);
    checkOutput("drop busy before", 64'(busy32 & busy8), 1);
    enable = 1'b0;
    tick(1);
    applyStimulus(noise());
    tick(1);
    checkAll("dropped");
    enable = 1'b1;
    tick(2);
    run_iter(20, "reenable20");

    $display("[TB] clear coincident with end marker");
    run_iter(15, "pre_clear15");
    applyStimulus(16'h00A5);
    tick(1);
    fill(24);
    applyStimulus(16'h005A);
    tick(1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    model_reset();
    checkAll("clear_on_end");
    tick(1);
    checkOutput("clear_on_end lv next", 64'(lv32 | lv8), 0);
    applyStimulus(noise());
    tick(2);

    $display("[TB] randomized rounds");
    for (int r = 0; r < 6; r++) begin
      do_clear($sformatf("rnd%0d clear", r));
      for (int j = $urandom_range(0, 4); j > 0 && !m_done; j--) begin
        repeat ($urandom_range(0, 5)) begin applyStimulus(noise()); tick(1); end
        run_iter($urandom_range(1, 400), $sformatf("rnd%0d", r));
      end
      if (!m_done) begin
        applyStimulus(16'hAB51);
        tick(2);
        m_done = 1;
        applyStimulus(noise());
        tick(1);
        checkAll($sformatf("rnd%0d code", r));
      end
    end

    $display("[TB] asynchronous reset during count");
    do_clear("clear4");
    run_iter(12, "pre_reset12");
    applyStimulus(16'h00A5);
    tick(1);
    fill(30);
    checkOutput("reset busy before", 64'(busy32 & busy8), 1);
    #1 wb_rst_i = 1'b1;
    #1;
    model_reset();
    checkAll("async_reset");
    wb_rst_i = 1'b0;
    applyStimulus(noise());
    tick(3);
    run_iter(7, "post_reset7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
